// File: rtl/axi_adapter_arbiter_if.sv
// Bundle between the upstream requesters, the round-robin arbiter and the AXI adapter.
// type_i / adp_type_o: 0 = SINGLE_REQ, 1 = cache-line request.
interface axi_adapter_arbiter_if #(
  parameter int NR_PORTS     = 3,
  parameter int DATA_WIDTH   = 256,
  parameter int AXI_ID_WIDTH = 4,
  parameter int XLEN         = 64
);
  logic [NR_PORTS-1:0]                   req_i;
  logic [NR_PORTS-1:0]                   type_i;
  logic [NR_PORTS-1:0][XLEN-1:0]         addr_i;
  logic [NR_PORTS-1:0]                   we_i;
  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i;
  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0] be_i;
  logic [NR_PORTS-1:0][1:0]              size_i;
  logic [NR_PORTS-1:0]                   gnt_o;
  logic [NR_PORTS-1:0]                   valid_o;
  logic [DATA_WIDTH-1:0]                 rdata_o;
  logic [XLEN-1:0]                       critical_word_o;
  logic [NR_PORTS-1:0]                   critical_word_valid_o;

  logic                                  adp_busy_i;
  logic                                  adp_req_o;
  logic                                  adp_type_o;
  logic [XLEN-1:0]                       adp_addr_o;
  logic                                  adp_we_o;
  logic [DATA_WIDTH-1:0]                 adp_wdata_o;
  logic [DATA_WIDTH/8-1:0]               adp_be_o;
  logic [1:0]                            adp_size_o;
  logic [AXI_ID_WIDTH-1:0]               adp_id_o;
  logic                                  adp_gnt_i;
  logic                                  adp_valid_i;
  logic [DATA_WIDTH-1:0]                 adp_rdata_i;
  logic [AXI_ID_WIDTH-1:0]               adp_id_i;
  logic [XLEN-1:0]                       adp_critical_word_i;
  logic                                  adp_critical_word_valid_i;

  // master: the arbiter; slave: requesters plus adapter
  modport master (
    input  req_i, type_i, addr_i, we_i, wdata_i, be_i, size_i,
    output gnt_o, valid_o, rdata_o, critical_word_o, critical_word_valid_o,
    input  adp_busy_i, adp_gnt_i, adp_valid_i, adp_rdata_i, adp_id_i,
           adp_critical_word_i, adp_critical_word_valid_i,
    output adp_req_o, adp_type_o, adp_addr_o, adp_we_o, adp_wdata_o, adp_be_o,
           adp_size_o, adp_id_o
  );

  modport slave (
    output req_i, type_i, addr_i, we_i, wdata_i, be_i, size_i,
    input  gnt_o, valid_o, rdata_o, critical_word_o, critical_word_valid_o,
    output adp_busy_i, adp_gnt_i, adp_valid_i, adp_rdata_i, adp_id_i,
           adp_critical_word_i, adp_critical_word_valid_i,
    input  adp_req_o, adp_type_o, adp_addr_o, adp_we_o, adp_wdata_o, adp_be_o,
           adp_size_o, adp_id_o
  );
endinterface

// File: rtl/axi_adapter_arbiter.sv
// Round-robin arbiter in front of the cache-side AXI adapter: one transaction in flight,
// grant/completion/critical-word strobes steered back to the owning port.
module axi_adapter_arbiter_port #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             gnt,
  input  logic             vld,
  input  logic             cw_vld,
  output logic             own_gnt,
  output logic             own_vld,
  output logic             own_cw_vld
);
  logic hit;
  assign hit        = (sel == SEL_W'(IDX));
  assign own_gnt    = hit & gnt;
  assign own_vld    = hit & vld;
  assign own_cw_vld = hit & cw_vld;
endmodule

module axi_adapter_arbiter #(
  parameter int NR_PORTS     = 3,
  parameter int DATA_WIDTH   = 256,
  parameter int AXI_ID_WIDTH = 4,
  parameter int XLEN         = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  axi_adapter_arbiter_if.master bus
);
  localparam int SEL_W = $clog2(NR_PORTS);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d, rr_q, rr_d, pick, sel_nxt;
  logic [SEL_W:0]      idx;
  logic                found, adp_req, gnt_fire, vld_fire, cw_fire;
  logic [NR_PORTS-1:0] gnt_vec, vld_vec, cw_vec;

  // first requester at or above rr_q, wrapping modulo NR_PORTS
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      idx = {1'b0, rr_q} + (SEL_W+1)'(i);
      if (idx >= (SEL_W+1)'(NR_PORTS)) idx = idx - (SEL_W+1)'(NR_PORTS);
      if (!found && bus.req_i[idx[SEL_W-1:0]]) begin
        pick  = idx[SEL_W-1:0];
        found = 1'b1;
      end
    end
  end

  assign sel_nxt = (sel_q == SEL_W'(NR_PORTS-1)) ? '0 : sel_q + SEL_W'(1);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    adp_req  = 1'b0;
    gnt_fire = 1'b0;
    vld_fire = 1'b0;
    cw_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req_i && !bus.adp_busy_i) begin
          sel_d   = pick;
          state_d = REQ;
        end
      end
      REQ: begin
        adp_req = 1'b1;
        if (bus.adp_gnt_i) begin
          gnt_fire = 1'b1;
          rr_d     = sel_nxt;
          state_d  = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        cw_fire = bus.adp_critical_word_valid_i;
        if (bus.adp_valid_i) begin
          vld_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
    end
  end

  for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
    axi_adapter_arbiter_port #(.SEL_W(SEL_W), .IDX(p)) u_port (
      .sel        (sel_q),
      .gnt        (gnt_fire),
      .vld        (vld_fire),
      .cw_vld     (cw_fire),
      .own_gnt    (gnt_vec[p]),
      .own_vld    (vld_vec[p]),
      .own_cw_vld (cw_vec[p])
    );
  end

  assign bus.gnt_o                 = gnt_vec;
  assign bus.valid_o               = vld_vec;
  assign bus.critical_word_valid_o = cw_vec;
  assign bus.rdata_o               = bus.adp_rdata_i;
  assign bus.critical_word_o       = bus.adp_critical_word_i;

  assign bus.adp_req_o   = adp_req;
  assign bus.adp_type_o  = bus.type_i[sel_q];
  assign bus.adp_addr_o  = bus.addr_i[sel_q];
  assign bus.adp_we_o    = bus.we_i[sel_q];
  assign bus.adp_wdata_o = bus.wdata_i[sel_q];
  assign bus.adp_be_o    = bus.be_i[sel_q];
  assign bus.adp_size_o  = bus.size_i[sel_q];
  assign bus.adp_id_o    = AXI_ID_WIDTH'(sel_q);

  // requester protocol and adapter response sanity
  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == REQ) |-> bus.req_i[sel_q]);
  a_gnt_vld: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.adp_gnt_i && bus.adp_valid_i));
  a_resp_state: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.adp_valid_i || bus.adp_critical_word_valid_i) |-> (state_q == WAIT_RESP));
  a_resp_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == WAIT_RESP && bus.adp_valid_i) |-> (bus.adp_id_i == AXI_ID_WIDTH'(sel_q)));
endmodule

// File: tb/tb_axi_adapter_arbiter.sv
// Scoreboarded bench: expected transactions queued at stimulus time, checked as the
// adapter model sees requests and returns completions.
module tb_axi_adapter_arbiter;
  localparam int NP = 3, DW = 256, IW = 4, XL = 64;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  axi_adapter_arbiter_if #(.NR_PORTS(NP), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .XLEN(XL)) bus ();

  axi_adapter_arbiter #(.NR_PORTS(NP), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .XLEN(XL)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    int               port;
    logic [XL-1:0]    addr;
    logic             we;
    logic             typ;
    logic [DW/8-1:0]  be;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    rdata;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic program_port(input int p, input logic we, input logic typ, input logic [XL-1:0] addr);
    bus.we_i[p]    = we;
    bus.type_i[p]  = typ;
    bus.addr_i[p]  = addr;
    bus.wdata_i[p] = rnd();
    bus.be_i[p]    = we ? '1 : DW'(rnd());
    bus.size_i[p]  = 2'(p);
  endtask

  task automatic expect_txn(input int p);
    exp_t e;
    e.port  = p;
    e.addr  = bus.addr_i[p];
    e.we    = bus.we_i[p];
    e.typ   = bus.type_i[p];
    e.be    = bus.be_i[p];
    e.wdata = bus.wdata_i[p];
    e.rdata = rnd();
    sb.push_back(e);
  endtask

  task automatic wait_req(input int max_wait, output bit ok);
    int n = 0;
    while (bus.adp_req_o !== 1'b1 && n < max_wait) begin
      @(negedge clk_i); #1;
      n++;
    end
    ok = (bus.adp_req_o === 1'b1);
    if (!ok) chk("adp_req_timeout", 0, 1);
  endtask

  // adapter model for one transaction
  task automatic serve(input bit cw, input bit keep, input logic [NP-1:0] raise, input int max_wait);
    exp_t e;
    bit ok;
    logic [NP-1:0] oh;
    wait_req(max_wait, ok);
    if (!ok) return;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e  = sb.pop_front();
    oh = NP'(1) << e.port;
    chk("adp_id", bus.adp_id_o, IW'(e.port));
    chk("adp_addr", bus.adp_addr_o, e.addr);
    chk("adp_we", bus.adp_we_o, e.we);
    chk("adp_type", bus.adp_type_o, e.typ);
    chk("adp_be", bus.adp_be_o, e.be);
    chk("adp_wdata", bus.adp_wdata_o, e.wdata);
    chk("gnt_before", bus.gnt_o, 0);
    bus.adp_gnt_i = 1'b1;
    #1;
    chk("gnt", bus.gnt_o, oh);
    @(posedge clk_i); #1;
    bus.adp_gnt_i = 1'b0;
    if (!keep) bus.req_i[e.port] = 1'b0;
    bus.req_i = bus.req_i | raise;
    repeat (2) begin
      @(negedge clk_i); #1;
      chk("wait_quiet", {bus.adp_req_o, bus.gnt_o, bus.valid_o, bus.critical_word_valid_o}, 0);
    end
    if (cw) begin
      bus.adp_critical_word_i       = 64'h0000_0000_DEAD_BEEF;
      bus.adp_critical_word_valid_i = 1'b1;
      #1;
      chk("cw_valid", bus.critical_word_valid_o, oh);
      chk("cw_word", bus.critical_word_o, 64'h0000_0000_DEAD_BEEF);
      @(posedge clk_i); #1;
      bus.adp_critical_word_valid_i = 1'b0;
    end
    @(negedge clk_i);
    bus.adp_valid_i = 1'b1;
    bus.adp_id_i    = IW'(e.port);
    bus.adp_rdata_i = e.rdata;
    #1;
    chk("valid", bus.valid_o, oh);
    chk("rdata", bus.rdata_o, e.rdata);
    chk("gnt_at_valid", bus.gnt_o, 0);
    @(posedge clk_i); #1;
    bus.adp_valid_i = 1'b0;
    #1;
    chk("valid_clr", bus.valid_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bus.req_i = '0; bus.type_i = '0; bus.addr_i = '0; bus.we_i = '0;
    bus.wdata_i = '0; bus.be_i = '0; bus.size_i = '0;
    bus.adp_busy_i = 1'b0; bus.adp_gnt_i = 1'b0; bus.adp_valid_i = 1'b0;
    bus.adp_rdata_i = '0; bus.adp_id_i = '0; bus.adp_critical_word_i = '0;
    bus.adp_critical_word_valid_i = 1'b0;
    bus.addr_i[0] = 64'h0000_0000_0000_1000;
    bus.addr_i[1] = 64'h0000_0000_0000_2000;
    #1;
    // reset state
    chk("rst_adp_req", bus.adp_req_o, 0);
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_cwv", bus.critical_word_valid_o, 0);
    chk("rst_id", bus.adp_id_o, 0);
    chk("rst_addr_port0", bus.adp_addr_o, 64'h1000);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i); #1;

    // single read on port 0, request one cycle after req
    program_port(0, 1'b0, 1'b0, 64'h0000_0000_8000_0010);
    expect_txn(0);
    bus.req_i = 3'b001;
    serve(1'b0, 1'b0, 3'b000, 1);

    // adapter busy blocks arbitration
    @(negedge clk_i); #1;
    program_port(1, 1'b0, 1'b0, 64'h0000_0000_8000_0100);
    bus.adp_busy_i = 1'b1;
    bus.req_i = 3'b010;
    repeat (4) begin
      @(negedge clk_i); #1;
      chk("busy_no_req", bus.adp_req_o, 0);
    end
    expect_txn(1);
    bus.adp_busy_i = 1'b0;
    serve(1'b0, 1'b0, 3'b000, 1);

    // asynchronous reset while waiting for the response
    @(negedge clk_i); #1;
    program_port(0, 1'b0, 1'b1, 64'h0000_0000_8000_0200);
    bus.req_i = 3'b001;
    wait_req(50, ok);
    bus.adp_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    bus.adp_gnt_i = 1'b0;
    bus.req_i = 3'b000;
    @(negedge clk_i); #1;
    bus.adp_critical_word_valid_i = 1'b1;
    #1;
    chk("pre_rst_cwv", bus.critical_word_valid_o, 3'b001);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_cwv", bus.critical_word_valid_o, 0);
    chk("async_rst_req", bus.adp_req_o, 0);
    chk("async_rst_gnt", bus.gnt_o, 0);
    chk("async_rst_valid", bus.valid_o, 0);
    bus.adp_critical_word_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i); #1;
    chk("post_rst_idle", bus.adp_req_o, 0);

    // all ports held: 0,1,2 then wrap to 0
    program_port(0, 1'b0, 1'b0, 64'h0000_0000_8000_1000);
    program_port(1, 1'b1, 1'b0, 64'h0000_0000_8000_2000);
    program_port(2, 1'b0, 1'b1, 64'h0000_0000_8000_3000);
    expect_txn(0); expect_txn(1); expect_txn(2); expect_txn(0);
    bus.req_i = 3'b111;
    for (int k = 0; k < 4; k++) serve(1'b0, 1'b1, 3'b000, 50);
    bus.req_i = 3'b000;

    // cache-line read on port 2 with critical word
    @(negedge clk_i); #1;
    program_port(2, 1'b0, 1'b1, 64'h0000_0000_8000_4000);
    expect_txn(2);
    bus.req_i = 3'b100;
    serve(1'b1, 1'b0, 3'b000, 50);

    // port 1 write; port 0 arrives mid-flight and waits for the completion
    @(negedge clk_i); #1;
    program_port(1, 1'b1, 1'b1, 64'h0000_0000_8000_5000);
    program_port(0, 1'b0, 1'b0, 64'h0000_0000_8000_6000);
    expect_txn(1);
    expect_txn(0);
    bus.req_i = 3'b010;
    serve(1'b0, 1'b0, 3'b001, 50);
    serve(1'b0, 1'b0, 3'b000, 2);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_adapter_arbiter.md
Name: axi_adapter_arbiter

Overview:
- Round-robin arbiter directly upstream of the cache-side AXI adapter.
- Multiplexes NR_PORTS requesters (e.g. miss unit, bypass, writeback) onto the adapter's single request interface.
- Keeps exactly one transaction in flight.
- Routes the adapter's grant, read data, critical word and completion back to the port that owns the transaction.

Parameters:
- NR_PORTS, 3, number of upstream requesters (2..8)
- DATA_WIDTH, 256, cache-line width in bits (multiple of riscv::XLEN)
- AXI_ID_WIDTH, 4, width of adapter ID; must be >= $clog2(NR_PORTS)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- req_i  in  NR_PORTS  per-port request
- type_i  in  NR_PORTS x ariane_axi::ad_req_t  SINGLE_REQ or cache-line request
- addr_i  in  NR_PORTS x riscv::XLEN  request address
- we_i  in  NR_PORTS  write enable
- wdata_i  in  NR_PORTS x DATA_WIDTH  write data
- be_i  in  NR_PORTS x DATA_WIDTH/8  byte enables
- size_i  in  NR_PORTS x 2  access size
- gnt_o  out  NR_PORTS  one-hot grant pulse
- valid_o  out  NR_PORTS  one-hot completion pulse
- rdata_o  out  DATA_WIDTH  read line, broadcast to all ports
- critical_word_o  out  riscv::XLEN  critical word, broadcast
- critical_word_valid_o  out  NR_PORTS  one-hot critical-word strobe
- adp_busy_i  in  1  adapter busy
- adp_req_o  out  1  request to adapter
- adp_type_o, adp_addr_o, adp_we_o, adp_wdata_o, adp_be_o, adp_size_o  out  widths as above  muxed request fields
- adp_id_o  out  AXI_ID_WIDTH  owning port index, zero-extended
- adp_gnt_i  in  1  adapter grant
- adp_valid_i  in  1  adapter completion
- adp_rdata_i  in  DATA_WIDTH  adapter read data
- adp_id_i  in  AXI_ID_WIDTH  adapter response ID
- adp_critical_word_i  in  riscv::XLEN  adapter critical word
- adp_critical_word_valid_i  in  1  adapter critical-word strobe

Behaviour:
- State machine and counters:
  - FSM states: IDLE, REQ, WAIT_RESP.
  - Registers: sel_q (owning port index), rr_q (round-robin start pointer).
  - Reset values: state_q=IDLE, sel_q=0, rr_q=0.
  - At reset, all outputs are 0: adp_req_o=0, gnt_o=0, valid_o=0, critical_word_valid_o=0.
  - Mux/broadcast data outputs show port 0 fields and adapter data.
- IDLE:
  - If any req_i is set and adp_busy_i=0, pick the first set bit searching from rr_q upward, modulo NR_PORTS.
  - Set sel_q=pick and go to REQ.
  - adp_req_o=0 in this state, so arbitration costs exactly 1 cycle.
- REQ:
  - adp_req_o=1; all adp_* fields are combinationally muxed from port sel_q; adp_id_o=sel_q.
  - On adp_gnt_i: gnt_o[sel_q]=1 in the same cycle, rr_q=(sel_q+1) mod NR_PORTS, go to WAIT_RESP.
  - Requesters must hold req and all fields stable until gnt_o. The arbiter does not check this; deassertion before grant is a protocol violation, flagged by an assertion.
- WAIT_RESP:
  - adp_req_o=0.
  - adp_critical_word_valid_i is routed to critical_word_valid_o[sel_q].
  - On adp_valid_i: valid_o[sel_q]=1 for 1 cycle, go to IDLE.
  - rdata_o and critical_word_o are broadcast unregistered; valid only alongside the strobe.
- Simultaneous / boundary events:
  - adp_gnt_i and adp_valid_i in the same cycle cannot occur; assertion.
  - adp_valid_i or adp_critical_word_valid_i outside WAIT_RESP is ignored; assertion.
  - adp_id_i != sel_q at adp_valid_i is an assertion error; routing uses sel_q only.
  - Requests arriving in REQ/WAIT_RESP wait; no grant is lost, the requester keeps req high.
  - Wrap-around: rr_q = NR_PORTS-1 followed by a grant wraps to 0.
  - A single requester gets back-to-back service; throughput is 1 transaction per (arb + adapter) latency.
  - Reset mid-transaction returns to IDLE immediately and asynchronously; any in-flight adapter transaction is abandoned (the adapter is reset by the same rst_ni).

Test Plan:
- Reset, then req_i=3'b001, read SINGLE_REQ addr 0x8000_0010 → adp_req_o rises 1 cycle later with adp_id_o=0; on adp_gnt_i, gnt_o=3'b001; on adp_valid_i, valid_o=3'b001 and rdata_o=adp_rdata_i.
- req_i=3'b111 held continuously → grants in order port 0,1,2,0; rr_q wraps from 2 to 0.
- Cache-line read on port 2; adapter pulses adp_critical_word_valid_i with word 0xDEAD_BEEF → critical_word_valid_o=3'b100 and critical_word_o=0xDEAD_BEEF.
- Port 1 write (we=1, cache line, be all ones) while port 0 raises req during WAIT_RESP → port 0 is not granted until valid_o[1] pulses; port 0 is then granted within 2 cycles.
- adp_busy_i=1 with req_i=3'b010 → stays IDLE, adp_req_o=0 until busy drops.
- Assert rst_ni low during WAIT_RESP → all outputs 0 asynchronously; after release, state is IDLE and rr_q=0.
